// File: rtl/mano_pkg.sv
// Shared definitions for the Mano instruction-cycle controller: cycle phases,
// opcode values, IR bit positions and the per-opcode last execute step.
package mano_pkg;

    // Nine phases need a 4-bit encoding, so phase_out is 4 bits wide.
    typedef enum logic [3:0] {
        PH_HALT   = 4'd0,
        PH_FETCH  = 4'd1,
        PH_DECODE = 4'd2,
        PH_INTR   = 4'd3,
        PH_ADDR   = 4'd4,
        PH_REGREF = 4'd5,
        PH_IO     = 4'd6,
        PH_EXEC   = 4'd7,
        PH_FAULT  = 4'd8
    } phase_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_IO  = 3'd7;

    localparam int HLT_BIT = 0;
    localparam int IOF_BIT = 6;
    localparam int ION_BIT = 7;

    // Last execute step (0 = T4) for opcodes AND..ISZ.
    localparam logic [1:0] LAST_STEP [0:6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/opcode_decoder.sv
// 3-to-8 one-hot decode of the IR opcode field.
module opcode_decoder (
    input  logic [2:0] opcode,
    output logic [7:0] op_onehot
);

    always_comb begin
        op_onehot         = '0;
        op_onehot[opcode] = 1'b1;
    end

endmodule

// File: rtl/instruction_cycle_controller.sv
// Mano instruction-cycle sequencer: decodes the one-hot timer and IR fields into a
// cycle phase, drives the sequence counter clear and owns the S, R and IEN flip-flops.
module instruction_cycle_controller
    import mano_pkg::*;
#(
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [TIMER_WIDTH-1:0] timer_in,
    input  logic [2:0]             opcode_in,
    input  logic                   indirect_in,
    input  logic [11:0]            ir_low_in,
    input  logic                   start_in,
    input  logic                   fgi_in,
    input  logic                   fgo_in,
    output logic                   sc_clear_out,
    output logic [3:0]             phase_out,
    output logic [1:0]             exec_step_out,
    output logic                   running_out,
    output logic                   ien_out,
    output logic                   r_out
);

    logic       run_q;
    logic       intr_q;
    logic       ien_q;
    logic [7:0] op_onehot;
    logic       timer_onehot;
    logic       beyond_t6;
    logic       early_t;
    logic [1:0] last_step;
    logic [1:0] cur_step;
    phase_t     phase;
    logic       sc_clear;
    logic [1:0] exec_step;
    logic       unused_ir_bits;

    opcode_decoder u_decoder (
        .opcode    (opcode_in),
        .op_onehot (op_onehot)
    );

    assign timer_onehot   = (timer_in != '0) && ((timer_in & (timer_in - TIMER_WIDTH'(1))) == '0);
    assign beyond_t6      = |(timer_in >> 7);
    assign early_t        = |timer_in[2:0];
    assign cur_step       = timer_in[4] ? 2'd0 : (timer_in[5] ? 2'd1 : 2'd2);
    assign unused_ir_bits = ^{ir_low_in[11:8], ir_low_in[5:1]};

    always_comb begin
        last_step = 2'd0;
        for (int i = 0; i < 7; i++) begin
            if (op_onehot[i]) begin
                last_step = LAST_STEP[i];
            end
        end
    end

    // Anything not matched below (bad timer, step past the opcode's end, IO at T4+) is FAULT.
    always_comb begin
        phase     = PH_FAULT;
        sc_clear  = 1'b1;
        exec_step = 2'd0;
        if (!run_q) begin
            phase = PH_HALT;
        end else if (timer_onehot && !beyond_t6) begin
            if (timer_in[0] || timer_in[1]) begin
                phase    = intr_q ? PH_INTR : PH_FETCH;
                sc_clear = 1'b0;
            end else if (timer_in[2]) begin
                phase    = intr_q ? PH_INTR : PH_DECODE;
                sc_clear = intr_q;
            end else if (timer_in[3]) begin
                if (op_onehot[OP_IO]) begin
                    phase = indirect_in ? PH_IO : PH_REGREF;
                end else begin
                    phase    = PH_ADDR;
                    sc_clear = 1'b0;
                end
            end else if (!op_onehot[OP_IO] && (cur_step <= last_step)) begin
                phase     = PH_EXEC;
                exec_step = cur_step;
                sc_clear  = (cur_step == last_step);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            intr_q <= 1'b0;
            ien_q  <= 1'b0;
        end else if (!run_q) begin
            run_q <= start_in;
        end else begin
            if (!early_t && ien_q && (fgi_in || fgo_in)) begin
                intr_q <= 1'b1;
            end
            case (phase)
                PH_INTR: begin
                    if (timer_in[2]) begin
                        intr_q <= 1'b0;
                        ien_q  <= 1'b0;
                    end
                end
                PH_REGREF: begin
                    if (ir_low_in[HLT_BIT]) begin
                        run_q <= 1'b0;
                    end
                end
                PH_IO: begin
                    if (ir_low_in[IOF_BIT]) begin
                        ien_q <= 1'b0;
                    end else if (ir_low_in[ION_BIT]) begin
                        ien_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sc_clear_out  = sc_clear;
    assign phase_out     = phase;
    assign exec_step_out = exec_step;
    assign running_out   = run_q;
    assign ien_out       = ien_q;
    assign r_out         = intr_q;

endmodule

// File: tb/tb_instruction_cycle_controller.sv
// Bench for instruction_cycle_controller paired with a 4-bit sequence counter stand-in;
// hand sequences, a forced-timer vector table, then randomized run against a reference model.
module tb_instruction_cycle_controller;
    import mano_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [15:0] timer_in;
    logic [2:0]  opcode_in;
    logic        indirect_in;
    logic [11:0] ir_low_in;
    logic        start_in;
    logic        fgi_in;
    logic        fgo_in;
    logic        sc_clear_out;
    logic [3:0]  phase_out;
    logic [1:0]  exec_step_out;
    logic        running_out;
    logic        ien_out;
    logic        r_out;

    logic [15:0] sc_timer;
    logic        force_timer;
    logic [15:0] forced_timer;
    int          checks;
    int          failures;

    typedef struct packed {
        phase_t     phase;
        logic       clear;
        logic [1:0] step;
    } expect_t;

    typedef struct {
        logic [15:0] timer;
        logic [2:0]  op;
        logic        ind;
        phase_t      phase;
        logic        clear;
        logic [1:0]  step;
    } vec_t;

    vec_t    vecs[$];
    expect_t m_now;
    logic    m_s;
    logic    m_r;
    logic    m_ien;

    instruction_cycle_controller #(.TIMER_WIDTH(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .timer_in      (timer_in),
        .opcode_in     (opcode_in),
        .indirect_in   (indirect_in),
        .ir_low_in     (ir_low_in),
        .start_in      (start_in),
        .fgi_in        (fgi_in),
        .fgo_in        (fgo_in),
        .sc_clear_out  (sc_clear_out),
        .phase_out     (phase_out),
        .exec_step_out (exec_step_out),
        .running_out   (running_out),
        .ien_out       (ien_out),
        .r_out         (r_out)
    );

    always #5 clock = ~clock;

    assign timer_in = force_timer ? forced_timer : sc_timer;

    // Sequence counter stand-in: T0 after clear, otherwise advance and wrap after T15.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)          sc_timer <= 16'h0001;
        else if (sc_clear_out) sc_timer <= 16'h0001;
        else                   sc_timer <= {sc_timer[14:0], sc_timer[15]};
    end

    // Timer value at which each opcode's instruction finishes.
    function automatic int finishT(logic [2:0] op);
        case (op)
            3'd3, 3'd4: return 4;
            3'd6:       return 6;
            default:    return 5;
        endcase
    endfunction

    function automatic expect_t modelOutputs(logic [15:0] t, logic s, logic r, logic [2:0] op, logic ind);
        expect_t e;
        int      n;
        e.phase = PH_FAULT;
        e.clear = 1'b1;
        e.step  = 2'd0;
        if (!s) begin
            e.phase = PH_HALT;
            return e;
        end
        if ($countones(t) != 1) return e;
        n = $clog2(t);
        if (n <= 2) begin
            e.phase = r ? PH_INTR : ((n == 2) ? PH_DECODE : PH_FETCH);
            e.clear = r && (n == 2);
        end else if (n == 3) begin
            if (op == 3'd7) begin
                e.phase = ind ? PH_IO : PH_REGREF;
            end else begin
                e.phase = PH_ADDR;
                e.clear = 1'b0;
            end
        end else if (op != 3'd7 && n <= finishT(op)) begin
            e.phase = PH_EXEC;
            e.step  = 2'(n - 4);
            e.clear = (n == finishT(op));
        end
        return e;
    endfunction

    always_comb m_now = modelOutputs(timer_in, m_s, m_r, opcode_in, indirect_in);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s   <= 1'b0;
            m_r   <= 1'b0;
            m_ien <= 1'b0;
        end else if (!m_s) begin
            m_s <= start_in;
        end else begin
            if ((timer_in & 16'h0007) == 16'h0 && m_ien && (fgi_in || fgo_in)) m_r <= 1'b1;
            if (m_now.phase == PH_INTR && timer_in == 16'h0004) begin
                m_r   <= 1'b0;
                m_ien <= 1'b0;
            end
            if (m_now.phase == PH_REGREF && ir_low_in[0]) m_s <= 1'b0;
            if (m_now.phase == PH_IO) m_ien <= ir_low_in[6] ? 1'b0 : (ir_low_in[7] ? 1'b1 : m_ien);
        end
    end

    task automatic check1(string name, logic [15:0] actual, logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(string name, phase_t p, logic c, logic [1:0] st);
        check1({name, ".phase"}, 16'(phase_out), 16'(p));
        check1({name, ".clear"}, 16'(sc_clear_out), 16'(c));
        check1({name, ".step"}, 16'(exec_step_out), 16'(st));
    endtask

    task automatic applyStimulus(logic [2:0] op, logic ind, logic [11:0] irl, logic st, logic fi, logic fo);
        opcode_in   = op;
        indirect_in = ind;
        ir_low_in   = irl;
        start_in    = st;
        fgi_in      = fi;
        fgo_in      = fo;
    endtask

    task automatic stepCheck(string name, phase_t p, logic c, logic [1:0] st);
        #1 checkOutput(name, p, c, st);
        @(negedge clock);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        clock        = 1'b0;
        reset_n      = 1'b0;
        force_timer  = 1'b0;
        forced_timer = 16'h0001;
        applyStimulus(3'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Halted with start low
        repeat (3) begin
            @(negedge clock);
            #1 checkOutput("halt", PH_HALT, 1'b1, 2'd0);
            check1("halt.timer", timer_in, 16'h0001);
            check1("halt.regs", 16'({running_out, r_out, ien_out}), 16'h0);
        end

        // ADD direct
        @(negedge clock);
        applyStimulus(OP_ADD, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        stepCheck("add.halt", PH_HALT, 1'b1, 2'd0);
        start_in = 1'b0;
        stepCheck("add.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("add.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("add.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("add.t3", PH_ADDR, 1'b0, 2'd0);
        stepCheck("add.t4", PH_EXEC, 1'b0, 2'd0);
        stepCheck("add.t5", PH_EXEC, 1'b1, 2'd1);
        check1("add.back_t0", timer_in, 16'h0001);

        // ISZ indirect
        applyStimulus(OP_ISZ, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        stepCheck("isz.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("isz.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("isz.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("isz.t3", PH_ADDR, 1'b0, 2'd0);
        stepCheck("isz.t4", PH_EXEC, 1'b0, 2'd0);
        stepCheck("isz.t5", PH_EXEC, 1'b0, 2'd1);
        stepCheck("isz.t6", PH_EXEC, 1'b1, 2'd2);

        // STA finishes at T4
        applyStimulus(OP_STA, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        stepCheck("sta.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("sta.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("sta.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("sta.t3", PH_ADDR, 1'b0, 2'd0);
        stepCheck("sta.t4", PH_EXEC, 1'b1, 2'd0);
        check1("sta.back_t0", timer_in, 16'h0001);

        // ION, then an interrupt request during T3 of the next instruction
        applyStimulus(OP_IO, 1'b1, 12'h080, 1'b0, 1'b0, 1'b0);
        stepCheck("ion.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("ion.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("ion.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("ion.t3", PH_IO, 1'b1, 2'd0);
        check1("ion.ien", 16'(ien_out), 16'h1);
        applyStimulus(OP_ADD, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        stepCheck("irq.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("irq.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("irq.t2", PH_DECODE, 1'b0, 2'd0);
        fgi_in = 1'b1;
        check1("irq.r_before", 16'(r_out), 16'h0);
        stepCheck("irq.t3", PH_ADDR, 1'b0, 2'd0);
        fgi_in = 1'b0;
        check1("irq.r_set", 16'(r_out), 16'h1);
        stepCheck("irq.t4", PH_EXEC, 1'b0, 2'd0);
        stepCheck("irq.t5", PH_EXEC, 1'b1, 2'd1);
        stepCheck("intr.t0", PH_INTR, 1'b0, 2'd0);
        stepCheck("intr.t1", PH_INTR, 1'b0, 2'd0);
        stepCheck("intr.t2", PH_INTR, 1'b1, 2'd0);
        check1("intr.r_clear", 16'(r_out), 16'h0);
        check1("intr.ien_clear", 16'(ien_out), 16'h0);
        check1("intr.timer", timer_in, 16'h0001);

        // HLT wins over start on the same edge; start honoured one edge later
        applyStimulus(OP_IO, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0);
        stepCheck("hlt.t0", PH_FETCH, 1'b0, 2'd0);
        stepCheck("hlt.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("hlt.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("hlt.t3", PH_REGREF, 1'b1, 2'd0);
        check1("hlt.s_clear", 16'(running_out), 16'h0);
        stepCheck("hlt.halted", PH_HALT, 1'b1, 2'd0);
        check1("hlt.s_restart", 16'(running_out), 16'h1);
        stepCheck("hlt.restart_t0", PH_FETCH, 1'b0, 2'd0);
        applyStimulus(OP_AND, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        stepCheck("rst.t1", PH_FETCH, 1'b0, 2'd0);
        stepCheck("rst.t2", PH_DECODE, 1'b0, 2'd0);
        stepCheck("rst.t3", PH_ADDR, 1'b0, 2'd0);
        #1 checkOutput("rst.t4", PH_EXEC, 1'b0, 2'd0);
        #3 reset_n = 1'b0;
        #1 checkOutput("rst.async", PH_HALT, 1'b1, 2'd0);
        check1("rst.regs", 16'({running_out, r_out, ien_out}), 16'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Forced-timer decode table with S=1, R=0
        vecs.push_back('{16'h0001, 3'd0, 1'b0, PH_FETCH,  1'b0, 2'd0});
        vecs.push_back('{16'h0002, 3'd5, 1'b1, PH_FETCH,  1'b0, 2'd0});
        vecs.push_back('{16'h0004, 3'd2, 1'b0, PH_DECODE, 1'b0, 2'd0});
        vecs.push_back('{16'h0008, 3'd7, 1'b0, PH_REGREF, 1'b1, 2'd0});
        vecs.push_back('{16'h0008, 3'd7, 1'b1, PH_IO,     1'b1, 2'd0});
        vecs.push_back('{16'h0008, 3'd2, 1'b1, PH_ADDR,   1'b0, 2'd0});
        vecs.push_back('{16'h0010, 3'd0, 1'b0, PH_EXEC,   1'b0, 2'd0});
        vecs.push_back('{16'h0020, 3'd2, 1'b0, PH_EXEC,   1'b1, 2'd1});
        vecs.push_back('{16'h0040, 3'd0, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h0010, 3'd4, 1'b0, PH_EXEC,   1'b1, 2'd0});
        vecs.push_back('{16'h0020, 3'd3, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h0020, 3'd5, 1'b1, PH_EXEC,   1'b1, 2'd1});
        vecs.push_back('{16'h0020, 3'd6, 1'b0, PH_EXEC,   1'b0, 2'd1});
        vecs.push_back('{16'h0040, 3'd6, 1'b0, PH_EXEC,   1'b1, 2'd2});
        vecs.push_back('{16'h0010, 3'd7, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h0080, 3'd0, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h0003, 3'd0, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h0000, 3'd1, 1'b0, PH_FAULT,  1'b1, 2'd0});
        vecs.push_back('{16'h8000, 3'd1, 1'b0, PH_FAULT,  1'b1, 2'd0});
        start_in = 1'b1;
        @(negedge clock);
        start_in    = 1'b0;
        force_timer = 1'b1;
        #1 check1("table.running", 16'(running_out), 16'h1);
        for (int i = 0; i < vecs.size(); i++) begin
            forced_timer = vecs[i].timer;
            applyStimulus(vecs[i].op, vecs[i].ind, 12'h000, 1'b0, 1'b0, 1'b0);
            stepCheck($sformatf("vec%0d", i), vecs[i].phase, vecs[i].clear, vecs[i].step);
        end
        check1("table.held", 16'({running_out, r_out, ien_out}), 16'h4);

        // Randomized run against the reference model
        force_timer = 1'b0;
        reset_n     = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          {12'($urandom) & 12'hFFE} | 12'($urandom_range(0, 7) == 0),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 7) == 0);
            #1;
            check1($sformatf("rnd%0d.phase", n), 16'(phase_out), 16'(m_now.phase));
            check1($sformatf("rnd%0d.clear", n), 16'(sc_clear_out), 16'(m_now.clear));
            check1($sformatf("rnd%0d.step", n), 16'(exec_step_out), 16'(m_now.step));
            check1($sformatf("rnd%0d.s", n), 16'(running_out), 16'(m_s));
            check1($sformatf("rnd%0d.r", n), 16'(r_out), 16'(m_r));
            check1($sformatf("rnd%0d.ien", n), 16'(ien_out), 16'(m_ien));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
